text_bus_bridge: RTL and testbench

Memory-mapped bus target that sits directly downstream of the CPU's peripheral bus (strobe/we/addr/data out, data/ready back) at the text peripheral window. It decodes CPU bus transactions, exposes a four-register window, and queues written characters in a FIFO. A valid/ready character stream drains the FIFO into the text renderer. It is the first consumer of CPU bus strobes and the only source of bus read data and ready for its window.

---
 rtl/text_bus_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_text_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_bus_bridge.sv
// ---------------------------------------------------------------------------
// text_bus_bridge
//   Memory-mapped target for the text peripheral window on the CPU peripheral
//   bus. It decodes strobed bus transactions into a four-register window and
//   queues written characters in a FIFO. The FIFO drains to the text renderer
//   over a valid/ready character stream.
//
//   Register window (addr[1:0]):
//     0 TXDATA  W: push data[7:0]        R: 0
//     1 STATUS  R: bit0 empty, bit1 full, bit2 overflow, bits[16:8] count
//     2 CTRL    RW: bit0 out_en, bit1 irq_en; W bit7=1 clears FIFO+overflow
//     3 reserved, acknowledged, reads 0
//
//   Ports:
//     i_cpu_clk        clock (rising edge)
//     i_rst            asynchronous active-high reset
//     i_bus_clk        bus strobe; a 0->1 transition starts a transaction
//     i_bus_we         1 = write, 0 = read
//     i_bus_addr[31:0] byte address
//     i_bus_data[31:0] write data
//     o_bus_data[31:0] read data, held until the next accepted read
//     o_bus_data_ready one-cycle acknowledge
//     o_char[7:0]      FIFO head character
//     o_char_valid     head valid (non-empty and out_en)
//     i_char_ready     downstream accepts the head
//     o_irq            level interrupt: irq_en & empty, registered
//
//   Build option: define TEXT_BRIDGE_STALL_EN to hold writes to a full FIFO
//   pending (no acknowledge) until a pop frees a slot, instead of dropping
//   the character and setting overflow.
// ---------------------------------------------------------------------------
`ifndef TEXT_PERIPH_BASE
`define TEXT_PERIPH_BASE 32'h8000_1000
`endif

module text_bus_bridge #(
   parameter logic [31:0] BASE_ADDR  = `TEXT_PERIPH_BASE,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        i_cpu_clk,
   input  logic        i_rst,
   input  logic        i_bus_clk,
   input  logic        i_bus_we,
   input  logic [31:0] i_bus_addr,
   input  logic [31:0] i_bus_data,
   output logic [31:0] o_bus_data,
   output logic        o_bus_data_ready,
   output logic [7:0]  o_char,
   output logic        o_char_valid,
   input  logic        i_char_ready,
   output logic        o_irq
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_P = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_e;

   logic        r_prev;
   logic        r_out_en;
   logic        r_irq_en;
   logic        r_ready;
   logic        r_irq;
   logic [31:0] r_rdata;
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [7:0]  r_mem [FIFO_DEPTH];

   logic [AW:0] w_count;
   logic        w_empty;
   logic        w_full;
   logic        w_start;
   logic        w_hit;
   logic        w_accept;
   logic        w_rd;
   logic        w_tx_wr;
   logic        w_ctrl_wr;
   logic        w_clear;
   logic        w_pop;
   logic        w_push_req;
   logic        w_push;
   logic [7:0]  w_push_char;
   logic        w_ready_nxt;
   logic        w_ovf_rd;
   logic [31:0] w_rdata;
   reg_e        w_reg;
   logic        w_unused;

   // Pointers carry one extra wrap bit, so full and empty are distinguishable.
   assign w_count = r_wptr - r_rptr;
   assign w_empty = (w_count == '0);
   assign w_full  = (w_count == DEPTH_P);

   assign w_start   = i_bus_clk & ~r_prev;
   assign w_hit     = w_start & (i_bus_addr[31:2] == BASE_ADDR[31:2]);
   assign w_reg     = reg_e'(i_bus_addr[1:0]);
   assign w_rd      = w_accept & ~i_bus_we;
   assign w_tx_wr   = w_accept & i_bus_we & (w_reg == REG_TXDATA);
   assign w_ctrl_wr = w_accept & i_bus_we & (w_reg == REG_CTRL);
   assign w_clear   = w_ctrl_wr & i_bus_data[7];

   // A clear wins over a simultaneous pop or push.
   assign w_pop  = o_char_valid & i_char_ready & ~w_clear;
   assign w_push = w_push_req & (~w_full | w_pop) & ~w_clear;

   assign w_unused = ^{i_bus_data[31:8], i_bus_data[6:2]};

`ifdef TEXT_BRIDGE_STALL_EN
   logic       r_pend;
   logic [7:0] r_pend_char;
   logic       w_stall;

   // While a write is pending only CTRL writes are decoded, so software can
   // still enable the output or clear the FIFO to release the stall.
   assign w_accept    = w_hit & (~r_pend | (i_bus_we & (w_reg == REG_CTRL)));
   assign w_stall     = w_tx_wr & w_full & ~w_pop;
   assign w_push_req  = w_tx_wr | r_pend;
   assign w_push_char = r_pend ? r_pend_char : i_bus_data[7:0];
   // A clear while pending is acknowledged through its own CTRL write.
   assign w_ready_nxt = (w_accept & ~w_stall) | (r_pend & w_push);
   assign w_ovf_rd    = 1'b0;

   always_ff @(posedge i_cpu_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend      <= 1'b0;
         r_pend_char <= '0;
      end else if (w_clear || (r_pend && w_push)) begin
         r_pend      <= 1'b0;
      end else if (w_stall) begin
         r_pend      <= 1'b1;
         r_pend_char <= i_bus_data[7:0];
      end
   end
`else
   logic r_ovf;

   assign w_accept    = w_hit;
   assign w_push_req  = w_tx_wr;
   assign w_push_char = i_bus_data[7:0];
   assign w_ready_nxt = w_accept;
   assign w_ovf_rd    = r_ovf;

   always_ff @(posedge i_cpu_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_clear) begin
         r_ovf <= 1'b0;
      end else if (w_tx_wr && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end
   end
`endif

   // Read mux reflects the state before the sampling edge.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_rdata = '0;
      case (w_reg)
         REG_STATUS: w_rdata = {15'b0, 9'(w_count), 5'b0, w_ovf_rd, w_full, w_empty};
         REG_CTRL:   w_rdata = {30'b0, r_irq_en, r_out_en};
         default:    w_rdata = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge i_cpu_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev   <= 1'b0;
         r_out_en <= 1'b0;
         r_irq_en <= 1'b0;
         r_ready  <= 1'b0;
         r_irq    <= 1'b0;
         r_rdata  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
      end else begin
         r_prev  <= i_bus_clk;
         r_ready <= w_ready_nxt;
         r_irq   <= r_irq_en & w_empty;
         if (w_rd) begin
            r_rdata <= w_rdata;
         end
         if (w_ctrl_wr) begin
            r_out_en <= i_bus_data[0];
            r_irq_en <= i_bus_data[1];
         end
         if (w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
            if (w_push) begin
               r_wptr <= r_wptr + 1'b1;
            end
         end
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the
   // pointers, and o_char is forced to 0 while the FIFO is empty.
   always_ff @(posedge i_cpu_clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= w_push_char;
      end
   end

   assign o_bus_data       = r_rdata;
   assign o_bus_data_ready = r_ready;
   assign o_char           = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
   assign o_char_valid     = ~w_empty & r_out_en;
   assign o_irq            = r_irq;

endmodule

// File: tb/tb_text_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_text_bus_bridge
//   Directed scenarios plus a randomized phase. A queue-based reference model
//   predicts acknowledge, read data, stream head and interrupt every cycle.
// ---------------------------------------------------------------------------
module tb_text_bus_bridge;

   localparam logic [31:0] BASE  = 32'h8000_1000;
   localparam int          DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_clk = 1'b0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_data = '0;
   logic        char_ready = 1'b0;
   logic [31:0] o_bus_data;
   logic        o_bus_data_ready;
   logic [7:0]  o_char;
   logic        o_char_valid;
   logic        o_irq;

   always #5 clk = ~clk;

   text_bus_bridge #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_cpu_clk        (clk),
      .i_rst            (rst),
      .i_bus_clk        (bus_clk),
      .i_bus_we         (bus_we),
      .i_bus_addr       (bus_addr),
      .i_bus_data       (bus_data),
      .o_bus_data       (o_bus_data),
      .o_bus_data_ready (o_bus_data_ready),
      .o_char           (o_char),
      .o_char_valid     (o_char_valid),
      .i_char_ready     (char_ready),
      .o_irq            (o_irq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_q[$];
   bit          m_out_en, m_irq_en, m_ovf, m_prev, m_irq, m_rdy, m_pend;
   logic [7:0]  m_pend_char;
   logic [31:0] m_rdata;

   // observation helpers
   logic [7:0]  obs[$];
   int          n_ready;
   logic [31:0] last_rdata;
   bit          rand_ready;

   task automatic model_reset();
      m_q.delete();
      m_out_en = 0; m_irq_en = 0; m_ovf = 0; m_prev = 0;
      m_irq = 0; m_rdy = 0; m_pend = 0; m_pend_char = '0; m_rdata = '0;
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s       = '0;
      s[0]    = (m_q.size() == 0);
      s[1]    = (m_q.size() == DEPTH);
      s[2]    = m_ovf;
      s[16:8] = 9'(m_q.size());
      return s;
   endfunction

   // Advances the model across one clock edge using the inputs now driven.
   task automatic model_step();
      bit         hit, acc, pop, clr, wr_tx, full_pre, empty_pre;
      logic [1:0] off;
      hit = bus_clk && !m_prev && (bus_addr[31:2] == BASE[31:2]);
      off = bus_addr[1:0];
`ifdef TEXT_BRIDGE_STALL_EN
      acc = hit && (!m_pend || (bus_we && off == 2'd2));
`else
      acc = hit;
`endif
      empty_pre = (m_q.size() == 0);
      full_pre  = (m_q.size() == DEPTH);
      pop   = !empty_pre && m_out_en && char_ready;
      clr   = acc && bus_we && off == 2'd2 && bus_data[7];
      wr_tx = acc && bus_we && off == 2'd0;
      m_irq = m_irq_en && empty_pre;
      m_rdy = acc;
      if (acc && !bus_we)
         m_rdata = (off == 2'd1) ? model_status() :
                   (off == 2'd2) ? {30'b0, m_irq_en, m_out_en} : 32'h0;
      if (clr) begin
         m_q.delete(); m_ovf = 0; m_pend = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
`ifdef TEXT_BRIDGE_STALL_EN
         if (m_pend && pop) begin
            m_q.push_back(m_pend_char); m_pend = 0; m_rdy = 1;
         end
         if (wr_tx) begin
            if (!full_pre || pop) m_q.push_back(bus_data[7:0]);
            else begin m_pend = 1; m_pend_char = bus_data[7:0]; m_rdy = 0; end
         end
`else
         if (wr_tx) begin
            if (!full_pre || pop) m_q.push_back(bus_data[7:0]);
            else m_ovf = 1;
         end
`endif
      end
      if (acc && bus_we && off == 2'd2) begin
         m_out_en = bus_data[0];
         m_irq_en = bus_data[1];
      end
      m_prev = bus_clk;
   endtask

   // One clock: predict, advance, compare.
   task automatic cycle();
      if (rand_ready) char_ready = ($urandom_range(0, 1) == 1);
      if (o_char_valid && char_ready) obs.push_back(o_char);
      model_step();
      @(posedge clk); #1;
      check("ready", o_bus_data_ready, m_rdy);
      if (m_rdy) check("rdata", o_bus_data, m_rdata);
      if (o_bus_data_ready) begin n_ready++; last_rdata = o_bus_data; end
      check("valid", o_char_valid, m_q.size() != 0 && m_out_en);
      if (m_q.size() != 0) check("char", o_char, m_q[0]);
      check("irq", o_irq, m_irq);
   endtask

   task automatic bus_op(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input int hold);
      bus_clk = 1'b1; bus_we = we; bus_addr = addr; bus_data = data;
      repeat (hold) cycle();
      bus_clk = 1'b0;
      cycle();
   endtask

   task automatic read_status(input string tag, input logic [31:0] exp);
      last_rdata = 32'hDEAD_BEEF;
      bus_op(1'b0, BASE + 32'd1, 32'h0, 1);
      check(tag, last_rdata, exp);
   endtask

   initial begin
      int r0;
      n_ready = 0;
      rand_ready = 0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_bus_data", o_bus_data, 32'h0);
      check("rst_ready", o_bus_data_ready, 0);
      check("rst_char", o_char, 0);
      check("rst_valid", o_char_valid, 0);
      check("rst_irq", o_irq, 0);
      rst = 1'b0;
      cycle();

      // Status after reset
      read_status("status_reset", 32'h0000_0001);
      check("reset_irq", o_irq, 0);
      check("reset_valid", o_char_valid, 0);

      // Stream two characters
      bus_op(1'b1, BASE + 32'd2, 32'h1, 1);
      char_ready = 1'b1;
      obs.delete();
      bus_op(1'b1, BASE, 32'h41, 1);
      bus_op(1'b1, BASE, 32'h42, 1);
      cycle(); cycle();
      char_ready = 1'b0;
      check("stream_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("stream_first", obs[0], 8'h41);
         check("stream_second", obs[1], 8'h42);
      end
      read_status("status_drained", 32'h0000_0001);

      // Fill past capacity
      bus_op(1'b1, BASE + 32'd2, 32'h0, 1);
      for (int i = 0; i < DEPTH; i++) bus_op(1'b1, BASE, 32'h60 + i, 1);
      r0 = n_ready;
      bus_op(1'b1, BASE, 32'h7F, 1);
`ifdef TEXT_BRIDGE_STALL_EN
      check("stall_no_ready", n_ready - r0, 0);
      bus_op(1'b1, BASE + 32'd2, 32'h1, 1);
      char_ready = 1'b1;
      cycle();
      char_ready = 1'b0;
      cycle();
      read_status("status_stall_done", 32'h0000_1002);
`else
      check("drop_ready", n_ready - r0, 1);
      read_status("status_overflow", 32'h0000_1006);
`endif
      bus_op(1'b1, BASE + 32'd2, 32'h80, 1);

      // Held strobe: exactly one transaction
      r0 = n_ready;
      bus_op(1'b1, BASE, 32'h33, 5);
      check("held_ready_pulses", n_ready - r0, 1);
      read_status("status_held", 32'h0000_0100);
      r0 = n_ready;
      bus_op(1'b1, BASE + 32'd4, 32'h44, 1);
      check("outside_no_ready", n_ready - r0, 0);
      read_status("status_outside", 32'h0000_0100);

      // Interrupt
      bus_op(1'b1, BASE + 32'd2, 32'h80, 1);
      bus_op(1'b1, BASE + 32'd2, 32'h3, 1);
      check("irq_on", o_irq, 1);
      bus_op(1'b1, BASE, 32'h55, 1);
      check("irq_off", o_irq, 0);

      // Clear coinciding with a pop
      bus_op(1'b1, BASE + 32'd2, 32'h80, 1);
      bus_op(1'b1, BASE + 32'd2, 32'h1, 1);
      for (int i = 0; i < 3; i++) bus_op(1'b1, BASE, 32'h20 + i, 1);
      bus_clk = 1'b1; bus_we = 1'b1; bus_addr = BASE + 32'd2; bus_data = 32'h81;
      char_ready = 1'b1;
      cycle();
      check("clear_pop_valid", o_char_valid, 0);
      bus_clk = 1'b0; char_ready = 1'b0;
      cycle();
      read_status("status_clear_pop", 32'h0000_0001);

      // Randomized traffic
      rand_ready = 1;
      for (int k = 0; k < 250; k++) begin
         logic [31:0] a, d;
         bit          w;
         a = BASE + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a + 32'd4;
         w = ($urandom_range(0, 3) != 0);
         d = $urandom();
         if (a[1:0] == 2'd2 && $urandom_range(0, 7) != 0) d[7] = 1'b0;
         bus_op(w, a, d, $urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) cycle();
      end
      rand_ready = 0;
      char_ready = 1'b0;

      // Reset in the middle of a transaction
      bus_op(1'b1, BASE + 32'd2, 32'h80, 1);
      bus_op(1'b1, BASE + 32'd2, 32'h1, 1);
      bus_clk = 1'b1; bus_we = 1'b1; bus_addr = BASE; bus_data = 32'h77;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ready", o_bus_data_ready, 0);
      check("midrst_valid", o_char_valid, 0);
      check("midrst_char", o_char, 0);
      check("midrst_bus_data", o_bus_data, 32'h0);
      check("midrst_irq", o_irq, 0);
      bus_clk = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("midrst_ready_hold", o_bus_data_ready, 0);
      rst = 1'b0;
      cycle();
      read_status("status_after_rst", 32'h0000_0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
